mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 118 +++++++++++
 tb/tb_mult_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one pipelined signed multiplier among NREQ requesters.
// Results return in issue order, tagged with the requester ID, MUL_LAT+1 cycles after the grant.
module mult_arbiter #(
   parameter int BITWIDTH = 16,
   parameter int NREQ     = 4,
   parameter int MUL_LAT  = 2,
   parameter int IDW      = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     arb_en,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*BITWIDTH-1:0] req_a,
   input  logic [NREQ*BITWIDTH-1:0] req_b,
   output logic                     mul_en,
   output logic [BITWIDTH-1:0]      mul_a,
   output logic [BITWIDTH-1:0]      mul_b,
   input  logic [2*BITWIDTH-1:0]    mul_product,
   output logic [NREQ-1:0]          resp_valid,
   output logic [IDW-1:0]           resp_id,
   output logic [2*BITWIDTH-1:0]    resp_product,
   output logic                     busy
);

   logic [IDW-1:0]          r_ptr;
   logic                    r_mul_en;
   logic [IDW-1:0]          r_mul_id;
   logic [BITWIDTH-1:0]     r_mul_a;
   logic [BITWIDTH-1:0]     r_mul_b;
   logic [MUL_LAT-1:0]      r_tag_v;
   logic [IDW-1:0]          r_tag_id [MUL_LAT];
   logic [NREQ-1:0]         r_resp_valid;
   logic [IDW-1:0]          r_resp_id;
   logic [2*BITWIDTH-1:0]   r_resp_product;

   logic                    w_gnt_any;
   logic [IDW-1:0]          w_gnt_id;
   logic [IDW-1:0]          w_gnt_next;
   logic                    w_xfer;
   int                      w_idx;

   // Walk from the far end back toward ptr so the last hit is the nearest one.
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_id  = '0;
      w_idx     = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (req_valid[IDW'(w_idx)]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = IDW'(w_idx);
         end
      end
   end

   // Reset gates the grant so nothing is offered while the block is held clear.
   assign w_xfer     = w_gnt_any & arb_en & reset;
   assign w_gnt_next = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = w_xfer && (w_gnt_id == IDW'(gi));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr          <= '0;
         r_mul_en       <= 1'b0;
         r_mul_id       <= '0;
         r_mul_a        <= '0;
         r_mul_b        <= '0;
         r_tag_v[0]     <= 1'b0;
         r_tag_id[0]    <= '0;
         r_resp_valid   <= '0;
         r_resp_id      <= '0;
         r_resp_product <= '0;
      end else begin
         r_mul_en    <= w_xfer;
         r_tag_v[0]  <= r_mul_en;
         r_tag_id[0] <= r_mul_id;
         if (w_xfer) begin
            r_ptr    <= w_gnt_next;
            r_mul_id <= w_gnt_id;
            r_mul_a  <= req_a[w_gnt_id*BITWIDTH +: BITWIDTH];
            r_mul_b  <= req_b[w_gnt_id*BITWIDTH +: BITWIDTH];
         end
         // The oldest tag lines up with the product one cycle after it settles.
         r_resp_valid <= '0;
         if (r_tag_v[MUL_LAT-1]) begin
            r_resp_valid[r_tag_id[MUL_LAT-1]] <= 1'b1;
            r_resp_id                         <= r_tag_id[MUL_LAT-1];
            r_resp_product                    <= mul_product;
         end
      end
   end

   for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_tag_v[gi]  <= 1'b0;
            r_tag_id[gi] <= '0;
         end else begin
            r_tag_v[gi]  <= r_tag_v[gi-1];
            r_tag_id[gi] <= r_tag_id[gi-1];
         end
      end
   end

   assign mul_en       = r_mul_en;
   assign mul_a        = r_mul_a;
   assign mul_b        = r_mul_b;
   assign resp_valid   = r_resp_valid;
   assign resp_id      = r_resp_id;
   assign resp_product = r_resp_product;
   assign busy         = (|r_tag_v) | r_mul_en;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 2-stage signed multiplier model and an in-order
// scoreboard of expected responses (ID, product, emergence cycle).
module tb_mult_arbiter;

   localparam int BW = 16;
   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            arb_en;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*BW-1:0] req_a;
   logic [NR*BW-1:0] req_b;
   logic            mul_en;
   logic [BW-1:0]   mul_a;
   logic [BW-1:0]   mul_b;
   logic [2*BW-1:0] mul_product;
   logic [NR-1:0]   resp_valid;
   logic [1:0]      resp_id;
   logic [2*BW-1:0] resp_product;
   logic            busy;

   logic [BW-1:0]   opa [NR];
   logic [BW-1:0]   opb [NR];
   logic [2*BW-1:0] s1, s2;

   typedef struct {
      int              id;
      logic [2*BW-1:0] prod;
      int              cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   mult_arbiter #(.BITWIDTH(BW), .NREQ(NR), .MUL_LAT(2), .IDW(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .arb_en       (arb_en),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .mul_en       (mul_en),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_product  (mul_product),
      .resp_valid   (resp_valid),
      .resp_id      (resp_id),
      .resp_product (resp_product),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   assign req_a = {opa[3], opa[2], opa[1], opa[0]};
   assign req_b = {opb[3], opb[2], opb[1], opb[0]};

   always @(posedge clk) begin
      s1  <= $signed(mul_a) * $signed(mul_b);
      s2  <= s1;
      cyc <= cyc + 1;
   end
   assign mul_product = s2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, check the grant, optionally record the expected result.
   task automatic step(input logic [3:0] v, input logic en, input logic [3:0] exp_rdy,
                       input bit push);
      exp_t             e;
      logic signed [31:0] p;
      req_valid = v;
      arb_en    = en;
      #1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (push && exp_rdy != 4'b0000) begin
         for (int i = 0; i < NR; i++) begin
            if (exp_rdy == (4'b0001 << i)) begin
               p      = $signed(opa[i]) * $signed(opb[i]);
               e.id   = i;
               e.prod = p;
               e.cyc  = cyc + 4;
               q.push_back(e);
               $display("grant id=%0d a=%h b=%h expect=%h at cycle %0d", i, opa[i], opb[i], p, e.cyc);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (resp_valid !== 4'b0000) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_resp: observed resp_valid %b expected none", resp_valid);
         end else begin
            e = q.pop_front();
            $display("resp id=%0d product=%h cycle=%0d", resp_id, resp_product, cyc);
            chk("resp_valid", 64'(resp_valid), 64'(4'b0001 << e.id));
            chk("resp_id", 64'(resp_id), 64'(e.id));
            chk("resp_product", 64'(resp_product), 64'(e.prod));
            chk("resp_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   initial begin
      reset     = 1'b0;
      arb_en    = 1'b1;
      req_valid = 4'b1111;
      opa[0] = 16'h0003; opb[0] = 16'hFFFB;
      opa[1] = 16'h1234; opb[1] = 16'h0056;
      opa[2] = 16'hFF00; opb[2] = 16'h0100;
      opa[3] = 16'h7FFF; opb[3] = 16'h7FFF;
      #2;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_mul_en", 64'(mul_en), 64'(0));
      chk("rst_mul_a", 64'(mul_a), 64'(0));
      chk("rst_mul_b", 64'(mul_b), 64'(0));
      chk("rst_resp_valid", 64'(resp_valid), 64'(0));
      chk("rst_resp_id", 64'(resp_id), 64'(0));
      chk("rst_resp_product", 64'(resp_product), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // All four requesters for eight cycles: strict 0,1,2,3 rotation.
      for (int n = 0; n < 8; n++) step(4'b1111, 1'b1, 4'b0001 << (n % 4), 1'b1);
      for (int n = 0; n < 4; n++) step(4'b0000, 1'b1, 4'b0000, 1'b1);

      // Single request 3 * -5.
      step(4'b0001, 1'b1, 4'b0001, 1'b1);
      chk("single_mul_en", 64'(mul_en), 64'(1));
      chk("single_mul_a", 64'(mul_a), 64'h0003);
      chk("single_mul_b", 64'(mul_b), 64'hFFFB);
      chk("single_busy", 64'(busy), 64'(1));
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      chk("single_mul_en_drop", 64'(mul_en), 64'(0));
      chk("single_mul_a_hold", 64'(mul_a), 64'h0003);
      chk("single_busy_mid", 64'(busy), 64'(1));
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      chk("single_resp_valid", 64'(resp_valid), 64'b0001);
      chk("single_resp_id", 64'(resp_id), 64'(0));
      chk("single_resp_product", 64'(resp_product), 64'hFFFFFFF1);
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      chk("single_busy_after", 64'(busy), 64'(0));
      chk("single_resp_valid_off", 64'(resp_valid), 64'(0));
      chk("single_resp_product_hold", 64'(resp_product), 64'hFFFFFFF1);

      // Move ptr to 2, then req1/req3 alternate starting with 3.
      step(4'b0010, 1'b1, 4'b0010, 1'b1);
      for (int n = 0; n < 4; n++)
         step(4'b1010, 1'b1, (n % 2 == 0) ? 4'b1000 : 4'b0010, 1'b1);
      for (int n = 0; n < 4; n++) step(4'b0000, 1'b1, 4'b0000, 1'b1);

      // Two grants, then arb_en drops; in-flight results still drain.
      step(4'b1111, 1'b1, 4'b0100, 1'b1);
      step(4'b1111, 1'b1, 4'b1000, 1'b1);
      for (int n = 0; n < 3; n++) step(4'b1111, 1'b0, 4'b0000, 1'b1);
      step(4'b0010, 1'b0, 4'b0000, 1'b1);
      chk("drain_busy", 64'(busy), 64'(0));
      step(4'b1111, 1'b1, 4'b0001, 1'b1);
      for (int n = 0; n < 4; n++) step(4'b0000, 1'b1, 4'b0000, 1'b1);

      // Operand extremes, back-to-back from one active requester.
      opa[0] = 16'h8000; opb[0] = 16'h8000;
      step(4'b0001, 1'b1, 4'b0001, 1'b1);
      opa[0] = 16'h7FFF;
      step(4'b0001, 1'b1, 4'b0001, 1'b1);
      chk("ext_mul_a", 64'(mul_a), 64'h7FFF);
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      chk("ext_min_min", 64'(resp_product), 64'h40000000);
      step(4'b0000, 1'b1, 4'b0000, 1'b1);
      chk("ext_max_min", 64'(resp_product), 64'hC0008000);
      for (int n = 0; n < 2; n++) step(4'b0000, 1'b1, 4'b0000, 1'b1);

      // Grant to req2 (ptr -> 3), then reset discards it.
      step(4'b0100, 1'b1, 4'b0100, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_req_ready", 64'(req_ready), 64'(0));
      chk("mid_rst_mul_en", 64'(mul_en), 64'(0));
      chk("mid_rst_mul_a", 64'(mul_a), 64'(0));
      chk("mid_rst_mul_b", 64'(mul_b), 64'(0));
      chk("mid_rst_resp_product", 64'(resp_product), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(4'b1010, 1'b1, 4'b0010, 1'b1);
      for (int n = 0; n < 6; n++) step(4'b0000, 1'b1, 4'b0000, 1'b1);

      chk("scoreboard_empty", 64'(q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
